// File: rtl/dff_bank_univ.sv
// Parametrised D flip-flop bank with synchronous clear/preset, clock enable,
// bit-masked set/clear/toggle, serial shift and rotate.
module dff_bank_univ #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sout,
    output logic             chg
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SET  = 3'b010,
        OP_CLR  = 3'b011,
        OP_TGL  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_ROL  = 3'b111
    } op_e;

    logic [WIDTH-1:0] q_nxt;
    logic             sout_nxt;
    logic             chg_nxt;

    // Next-state decode: clr > pre > enable-hold > op
    always_comb begin
        q_nxt    = q;
        sout_nxt = sout;
        if (clr) begin
            q_nxt    = RESET_VAL;
            sout_nxt = 1'b0;
        end else if (pre) begin
            q_nxt    = '1;
            sout_nxt = 1'b0;
        end else if (en) begin
            case (op_e'(op))
                OP_HOLD: q_nxt = q;
                OP_LOAD: q_nxt = d;
                OP_SET:  q_nxt = q | d;
                OP_CLR:  q_nxt = q & ~d;
                OP_TGL:  q_nxt = q ^ d;
                OP_SHL: begin
                    q_nxt    = {q[WIDTH-2:0], sin};
                    sout_nxt = q[WIDTH-1];
                end
                OP_SHR: begin
                    q_nxt    = {sin, q[WIDTH-1:1]};
                    sout_nxt = q[0];
                end
                OP_ROL: begin
                    q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
                    sout_nxt = q[WIDTH-1];
                end
                default: q_nxt = q;
            endcase
        end
    end

    assign chg_nxt = (q_nxt != q);

    always_ff @(posedge clk) begin
        q    <= q_nxt;
        sout <= sout_nxt;
        chg  <= chg_nxt;
    end

    // Complement tracks q with no extra register stage
    assign qn = ~q;

endmodule

// File: tb/tb_dff_bank_univ.sv
// Self-checking bench for dff_bank_univ: directed vector table, ROL round-trip
// sequences and randomized stimulus against an arithmetic reference model.
module tb_dff_bank_univ;

    localparam int unsigned W = 8;
    localparam logic [W-1:0] RV = 8'hA5;

    logic         clk;
    logic         clr, pre, en, sin;
    logic [2:0]   op;
    logic [W-1:0] d, q, qn;
    logic         sout, chg;

    int tests;
    int fails;

    // Reference model state
    logic [W-1:0] mq;
    logic         msout, mchg;

    typedef struct {
        logic         clr, pre, en;
        logic [2:0]   op;
        logic [W-1:0] d;
        logic         sin;
        logic [W-1:0] eq;
        logic         esout, echg, ck_chg;
    } vec_t;

    vec_t tbl[$];

    dff_bank_univ #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .clr(clr), .pre(pre), .en(en), .op(op), .d(d), .sin(sin),
        .q(q), .qn(qn), .sout(sout), .chg(chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic c, input logic p, input logic e,
                                input logic [2:0] o, input logic [W-1:0] dd,
                                input logic s, input logic [W-1:0] xq,
                                input logic xs, input logic xc, input logic kc);
        vec_t v;
        v.clr = c; v.pre = p; v.en = e; v.op = o; v.d = dd; v.sin = s;
        v.eq = xq; v.esout = xs; v.echg = xc; v.ck_chg = kc;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: integer arithmetic on the register value
    task automatic model_step();
        int v, o, so;
        logic [W-1:0] nq;
        o  = int'(mq);
        v  = o;
        so = int'(msout);
        if (clr) begin
            v = int'(RV); so = 0;
        end else if (pre) begin
            v = 255; so = 0;
        end else if (en) begin
            case (op)
                3'd1: v = int'(d);
                3'd2: v = o | int'(d);
                3'd3: v = o & (255 - int'(d));
                3'd4: v = o ^ int'(d);
                3'd5: begin v = (o * 2) % 256 + int'(sin); so = o / 128; end
                3'd6: begin v = o / 2 + int'(sin) * 128;   so = o % 2;   end
                3'd7: begin v = (o * 2) % 256 + o / 128;   so = o / 128; end
                default: v = o;
            endcase
        end
        nq    = W'(v);
        mchg  = (nq != mq);
        mq    = nq;
        msout = so[0];
    endtask

    task automatic apply(input logic c, input logic p, input logic e,
                         input logic [2:0] o, input logic [W-1:0] dd, input logic s);
        clr = c; pre = p; en = e; op = o; d = dd; sin = s;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        logic [W-1:0] start;
        tests = 0;
        fails = 0;
        clr = 1'b0; pre = 1'b0; en = 1'b0; op = 3'd0; d = '0; sin = 1'b0;
        mq = 'x; msout = 'x; mchg = 'x;

        //            clr pre en op    d      sin  q      sout chg ck
        tbl.push_back(mk(1, 0, 0, 3'd0, 8'h00, 0, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3'd0, 8'h00, 0, 8'hA5, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3'd1, 8'h3C, 0, 8'h3C, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd4, 8'hFF, 0, 8'hC3, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd5, 8'h00, 1, 8'h87, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd5, 8'h00, 1, 8'h0F, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd5, 8'h00, 1, 8'h1F, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd1, 8'h81, 0, 8'h81, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd7, 8'h00, 0, 8'h03, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd7, 8'h00, 0, 8'h06, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd7, 8'h00, 0, 8'h0C, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd7, 8'h00, 0, 8'h18, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd7, 8'h00, 0, 8'h30, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd7, 8'h00, 0, 8'h60, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd7, 8'h00, 0, 8'hC0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd7, 8'h00, 0, 8'h81, 1, 1, 1));
        tbl.push_back(mk(1, 1, 1, 3'd1, 8'h00, 0, 8'hA5, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 3'd1, 8'h00, 0, 8'hFF, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd5, 8'h00, 1, 8'hFF, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 3'd1, 8'h00, 0, 8'hFF, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3'd2, 8'h00, 0, 8'hFF, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3'd3, 8'h0F, 0, 8'hF0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd4, 8'h00, 0, 8'hF0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 3'd5, 8'h00, 1, 8'hA5, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd6, 8'h00, 1, 8'hD2, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3'd0, 8'hFF, 0, 8'hD2, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 3'd0, 8'h00, 0, 8'hFF, 0, 1, 1));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].clr, tbl[i].pre, tbl[i].en, tbl[i].op, tbl[i].d, tbl[i].sin);
            check($sformatf("vec%0d_q", i), q, tbl[i].eq);
            check($sformatf("vec%0d_qn", i), qn, ~tbl[i].eq);
            check($sformatf("vec%0d_sout", i), W'(sout), W'(tbl[i].esout));
            if (tbl[i].ck_chg)
                check($sformatf("vec%0d_chg", i), W'(chg), W'(tbl[i].echg));
        end

        // ROL applied WIDTH times returns the starting value
        for (int r = 0; r < 4; r++) begin
            start = W'($urandom);
            apply(0, 0, 1, 3'd1, start, 0);
            for (int k = 0; k < W; k++) apply(0, 0, 1, 3'd7, '0, 0);
            check($sformatf("rol_roundtrip%0d", r), q, start);
        end

        // Randomized stimulus against the model
        for (int n = 0; n < 2000; n++) begin
            apply(($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 7) != 0), 3'($urandom), W'($urandom), 1'($urandom));
            check($sformatf("rnd%0d_q", n), q, mq);
            check($sformatf("rnd%0d_qn", n), qn, ~mq);
            check($sformatf("rnd%0d_sout", n), W'(sout), W'(msout));
            check($sformatf("rnd%0d_chg", n), W'(chg), W'(mchg));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
